// File: rtl/axis_ascon_aead128_arbiter.sv
// Round-robin arbiter sharing one axis_ascon_aead128 core between num_clients AXI-Stream
// requesters; ownership is held from the command grant until the core's output tag handshake.
module axis_ascon_aead128_arbiter #(
    parameter int unsigned  num_clients = 2,
    localparam int unsigned cw          = (num_clients > 1) ? $clog2(num_clients) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,

    // Client-side inputs
    input  logic [num_clients-1:0]     s_cmd_tvalid,
    output logic [num_clients-1:0]     s_cmd_tready,
    input  logic [num_clients*512-1:0] s_cmd_tdata,

    input  logic [num_clients-1:0]     s_ad_tvalid,
    output logic [num_clients-1:0]     s_ad_tready,
    input  logic [num_clients-1:0]     s_ad_tlast,
    input  logic [num_clients*128-1:0] s_ad_tdata,
    input  logic [num_clients*16-1:0]  s_ad_tkeep,

    input  logic [num_clients-1:0]     s_tvalid,
    output logic [num_clients-1:0]     s_tready,
    input  logic [num_clients-1:0]     s_tlast,
    input  logic [num_clients*128-1:0] s_tdata,
    input  logic [num_clients*16-1:0]  s_tkeep,

    input  logic [num_clients-1:0]     s_tag_tvalid,
    output logic [num_clients-1:0]     s_tag_tready,
    input  logic [num_clients*128-1:0] s_tag_tdata,

    // Client-side outputs
    output logic [num_clients-1:0]     m_ad_tvalid,
    input  logic [num_clients-1:0]     m_ad_tready,
    output logic [num_clients-1:0]     m_ad_tlast,
    output logic [num_clients*128-1:0] m_ad_tdata,
    output logic [num_clients*16-1:0]  m_ad_tkeep,

    output logic [num_clients-1:0]     m_tvalid,
    input  logic [num_clients-1:0]     m_tready,
    output logic [num_clients-1:0]     m_tlast,
    output logic [num_clients*128-1:0] m_tdata,
    output logic [num_clients*16-1:0]  m_tkeep,

    output logic [num_clients-1:0]     m_tag_tvalid,
    input  logic [num_clients-1:0]     m_tag_tready,
    output logic [num_clients*128-1:0] m_tag_tdata,

    // Core-facing inputs (driven by this block)
    output logic                       c_s_cmd_tvalid,
    input  logic                       c_s_cmd_tready,
    output logic [511:0]               c_s_cmd_tdata,

    output logic                       c_s_ad_tvalid,
    input  logic                       c_s_ad_tready,
    output logic                       c_s_ad_tlast,
    output logic [127:0]               c_s_ad_tdata,
    output logic [15:0]                c_s_ad_tkeep,

    output logic                       c_s_tvalid,
    input  logic                       c_s_tready,
    output logic                       c_s_tlast,
    output logic [127:0]               c_s_tdata,
    output logic [15:0]                c_s_tkeep,

    output logic                       c_s_tag_tvalid,
    input  logic                       c_s_tag_tready,
    output logic [127:0]               c_s_tag_tdata,

    // Core outputs
    input  logic                       c_m_ad_tvalid,
    output logic                       c_m_ad_tready,
    input  logic                       c_m_ad_tlast,
    input  logic [127:0]               c_m_ad_tdata,
    input  logic [15:0]                c_m_ad_tkeep,

    input  logic                       c_m_tvalid,
    output logic                       c_m_tready,
    input  logic                       c_m_tlast,
    input  logic [127:0]               c_m_tdata,
    input  logic [15:0]                c_m_tkeep,

    input  logic                       c_m_tag_tvalid,
    output logic                       c_m_tag_tready,
    input  logic [127:0]               c_m_tag_tdata,

    output logic                       busy,
    output logic [cw-1:0]              grant_id
);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StRun
    } state_e;

    state_e        state_q, state_d;
    logic [cw-1:0] grant_q, grant_d;
    logic [cw-1:0] rr_ptr_q, rr_ptr_d;
    logic          busy_q, busy_d;

    logic [cw-1:0] pick;
    logic [cw-1:0] idx;
    logic          any_req;

    // Search starts one past the last owner so the previous winner has lowest priority.
    always_comb begin
        pick    = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int unsigned i = 1; i <= num_clients; i++) begin
            idx = cw'((32'(rr_ptr_q) + i) % num_clients);
            if (!any_req && s_cmd_tvalid[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (c_s_cmd_tvalid && c_s_cmd_tready) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (c_m_tag_tvalid && c_m_tag_tready) begin
                    rr_ptr_d = grant_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= cw'(num_clients - 1);
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign grant_id = grant_q;

    // Payload fields follow the owner unconditionally; only handshake signals are gated.
    assign c_s_cmd_tdata = s_cmd_tdata[32'(grant_q)*512 +: 512];
    assign c_s_ad_tlast  = s_ad_tlast[grant_q];
    assign c_s_ad_tdata  = s_ad_tdata[32'(grant_q)*128 +: 128];
    assign c_s_ad_tkeep  = s_ad_tkeep[32'(grant_q)*16 +: 16];
    assign c_s_tlast     = s_tlast[grant_q];
    assign c_s_tdata     = s_tdata[32'(grant_q)*128 +: 128];
    assign c_s_tkeep     = s_tkeep[32'(grant_q)*16 +: 16];
    assign c_s_tag_tdata = s_tag_tdata[32'(grant_q)*128 +: 128];

    // Core outputs are broadcast; non-owners never see tvalid, so their copies are inert.
    assign m_ad_tlast  = {num_clients{c_m_ad_tlast}};
    assign m_ad_tdata  = {num_clients{c_m_ad_tdata}};
    assign m_ad_tkeep  = {num_clients{c_m_ad_tkeep}};
    assign m_tlast     = {num_clients{c_m_tlast}};
    assign m_tdata     = {num_clients{c_m_tdata}};
    assign m_tkeep     = {num_clients{c_m_tkeep}};
    assign m_tag_tdata = {num_clients{c_m_tag_tdata}};

    always_comb begin
        s_cmd_tready   = '0;
        s_ad_tready    = '0;
        s_tready       = '0;
        s_tag_tready   = '0;
        m_ad_tvalid    = '0;
        m_tvalid       = '0;
        m_tag_tvalid   = '0;
        c_s_cmd_tvalid = 1'b0;
        c_s_ad_tvalid  = 1'b0;
        c_s_tvalid     = 1'b0;
        c_s_tag_tvalid = 1'b0;
        c_m_ad_tready  = 1'b0;
        c_m_tready     = 1'b0;
        c_m_tag_tready = 1'b0;

        if (state_q == StCmd) begin
            c_s_cmd_tvalid        = s_cmd_tvalid[grant_q];
            s_cmd_tready[grant_q] = c_s_cmd_tready;
        end

        if (state_q == StRun) begin
            c_s_ad_tvalid         = s_ad_tvalid[grant_q];
            s_ad_tready[grant_q]  = c_s_ad_tready;
            c_s_tvalid            = s_tvalid[grant_q];
            s_tready[grant_q]     = c_s_tready;
            c_s_tag_tvalid        = s_tag_tvalid[grant_q];
            s_tag_tready[grant_q] = c_s_tag_tready;

            m_ad_tvalid[grant_q]  = c_m_ad_tvalid;
            c_m_ad_tready         = m_ad_tready[grant_q];
            m_tvalid[grant_q]     = c_m_tvalid;
            c_m_tready            = m_tready[grant_q];
            m_tag_tvalid[grant_q] = c_m_tag_tvalid;
            c_m_tag_tready        = m_tag_tready[grant_q];
        end
    end

endmodule

// File: tb/tb_axis_ascon_aead128_arbiter.sv
// Directed bench for axis_ascon_aead128_arbiter with three clients; the bench itself acts as
// the shared core, driving core outputs and readies and observing the muxed core inputs.
module tb_axis_ascon_aead128_arbiter;

    localparam int N  = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic resetn;

    logic [N-1:0]     s_cmd_tvalid, s_cmd_tready;
    logic [N*512-1:0] s_cmd_tdata;
    logic [N-1:0]     s_ad_tvalid, s_ad_tready, s_ad_tlast;
    logic [N*128-1:0] s_ad_tdata;
    logic [N*16-1:0]  s_ad_tkeep;
    logic [N-1:0]     s_tvalid, s_tready, s_tlast;
    logic [N*128-1:0] s_tdata;
    logic [N*16-1:0]  s_tkeep;
    logic [N-1:0]     s_tag_tvalid, s_tag_tready;
    logic [N*128-1:0] s_tag_tdata;
    logic [N-1:0]     m_ad_tvalid, m_ad_tready, m_ad_tlast;
    logic [N*128-1:0] m_ad_tdata;
    logic [N*16-1:0]  m_ad_tkeep;
    logic [N-1:0]     m_tvalid, m_tready, m_tlast;
    logic [N*128-1:0] m_tdata;
    logic [N*16-1:0]  m_tkeep;
    logic [N-1:0]     m_tag_tvalid, m_tag_tready;
    logic [N*128-1:0] m_tag_tdata;

    logic         c_s_cmd_tvalid, c_s_cmd_tready;
    logic [511:0] c_s_cmd_tdata;
    logic         c_s_ad_tvalid, c_s_ad_tready, c_s_ad_tlast;
    logic [127:0] c_s_ad_tdata;
    logic [15:0]  c_s_ad_tkeep;
    logic         c_s_tvalid, c_s_tready, c_s_tlast;
    logic [127:0] c_s_tdata;
    logic [15:0]  c_s_tkeep;
    logic         c_s_tag_tvalid, c_s_tag_tready;
    logic [127:0] c_s_tag_tdata;
    logic         c_m_ad_tvalid, c_m_ad_tready, c_m_ad_tlast;
    logic [127:0] c_m_ad_tdata;
    logic [15:0]  c_m_ad_tkeep;
    logic         c_m_tvalid, c_m_tready, c_m_tlast;
    logic [127:0] c_m_tdata;
    logic [15:0]  c_m_tkeep;
    logic         c_m_tag_tvalid, c_m_tag_tready;
    logic [127:0] c_m_tag_tdata;

    logic          busy;
    logic [CW-1:0] grant_id;

    axis_ascon_aead128_arbiter #(.num_clients(N)) dut (
        .clk(clk), .resetn(resetn),
        .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready), .s_cmd_tdata(s_cmd_tdata),
        .s_ad_tvalid(s_ad_tvalid), .s_ad_tready(s_ad_tready), .s_ad_tlast(s_ad_tlast),
        .s_ad_tdata(s_ad_tdata), .s_ad_tkeep(s_ad_tkeep),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready), .s_tag_tdata(s_tag_tdata),
        .m_ad_tvalid(m_ad_tvalid), .m_ad_tready(m_ad_tready), .m_ad_tlast(m_ad_tlast),
        .m_ad_tdata(m_ad_tdata), .m_ad_tkeep(m_ad_tkeep),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tag_tvalid(m_tag_tvalid), .m_tag_tready(m_tag_tready), .m_tag_tdata(m_tag_tdata),
        .c_s_cmd_tvalid(c_s_cmd_tvalid), .c_s_cmd_tready(c_s_cmd_tready),
        .c_s_cmd_tdata(c_s_cmd_tdata),
        .c_s_ad_tvalid(c_s_ad_tvalid), .c_s_ad_tready(c_s_ad_tready),
        .c_s_ad_tlast(c_s_ad_tlast), .c_s_ad_tdata(c_s_ad_tdata), .c_s_ad_tkeep(c_s_ad_tkeep),
        .c_s_tvalid(c_s_tvalid), .c_s_tready(c_s_tready), .c_s_tlast(c_s_tlast),
        .c_s_tdata(c_s_tdata), .c_s_tkeep(c_s_tkeep),
        .c_s_tag_tvalid(c_s_tag_tvalid), .c_s_tag_tready(c_s_tag_tready),
        .c_s_tag_tdata(c_s_tag_tdata),
        .c_m_ad_tvalid(c_m_ad_tvalid), .c_m_ad_tready(c_m_ad_tready),
        .c_m_ad_tlast(c_m_ad_tlast), .c_m_ad_tdata(c_m_ad_tdata), .c_m_ad_tkeep(c_m_ad_tkeep),
        .c_m_tvalid(c_m_tvalid), .c_m_tready(c_m_tready), .c_m_tlast(c_m_tlast),
        .c_m_tdata(c_m_tdata), .c_m_tkeep(c_m_tkeep),
        .c_m_tag_tvalid(c_m_tag_tvalid), .c_m_tag_tready(c_m_tag_tready),
        .c_m_tag_tdata(c_m_tag_tdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [511:0] cmd_word [N];
    logic [127:0] ad_v [2];
    logic [127:0] pt_v [3];

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        s_cmd_tvalid = '0; s_ad_tvalid = '0; s_tvalid = '0; s_tag_tvalid = '0;
        s_ad_tlast = '0; s_tlast = '0;
        m_ad_tready = '0; m_tready = '0; m_tag_tready = '0;
        c_s_cmd_tready = 1'b0; c_s_ad_tready = 1'b0; c_s_tready = 1'b0; c_s_tag_tready = 1'b0;
        c_m_ad_tvalid = 1'b0; c_m_tvalid = 1'b0; c_m_tag_tvalid = 1'b0;
        c_m_ad_tlast = 1'b0; c_m_tlast = 1'b0;
    endtask

    // Serve one message for client exp: wait for the grant, take the command, check gating
    // in RUN, then complete the core tag handshake. next_req replaces the request vector once
    // the command has been accepted.
    task automatic run_msg(input int exp, input logic [N-1:0] next_req);
        logic [N-1:0] oh;
        int waited;
        oh = '0;
        oh[exp] = 1'b1;
        waited = 0;
        while (!busy && waited < 8) begin
            tick();
            waited++;
        end
        check("grant_busy", busy, 1'b1);
        check("grant_id", grant_id, exp);
        check("cmd_data", c_s_cmd_tdata, cmd_word[exp]);
        c_s_cmd_tready = 1'b1;
        #1;
        check("cmd_rdy_mask", s_cmd_tready, oh);
        tick();
        c_s_cmd_tready = 1'b0;
        s_cmd_tvalid = next_req;
        s_ad_tvalid = '1; c_s_ad_tready = 1'b1; c_m_tvalid = 1'b1; m_tready = '1;
        #1;
        check("ad_rdy_mask", s_ad_tready, oh);
        check("m_vld_mask", m_tvalid, oh);
        check("cmd_rdy_run", s_cmd_tready, '0);
        s_ad_tvalid = '0; c_s_ad_tready = 1'b0; c_m_tvalid = 1'b0; m_tready = '0;
        c_m_tag_tvalid = 1'b1; m_tag_tready = '1;
        #1;
        check("tag_vld_mask", m_tag_tvalid, oh);
        tick();
        c_m_tag_tvalid = 1'b0; m_tag_tready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            cmd_word[k] = 512'(k + 1) | 512'(k + 16) << 400;
            cmd_word[k][256] = (k == 0);
        end
        ad_v[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        ad_v[1] = 128'h0A0B_0C0D_0E0F_1011_1213_1415_1617_1819;
        pt_v[0] = 128'hCAFE_0000_0000_0000_0000_0000_0000_0001;
        pt_v[1] = 128'hCAFE_0000_0000_0000_0000_0000_0000_0002;
        pt_v[2] = 128'h0000_0000_0000_0000_00CA_FE00_0000_0003;
        for (int k = 0; k < N; k++) s_cmd_tdata[k*512 +: 512] = cmd_word[k];
        s_ad_tdata = {N{128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF}};
        s_tdata = {N{128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0}};
        s_tag_tdata = {N{128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A}};
        s_ad_tkeep = {N{16'hFFFF}};
        s_tkeep = {N{16'h0F0F}};
        c_m_ad_tdata = '0; c_m_tdata = '0; c_m_tag_tdata = '0;
        c_m_ad_tkeep = '0; c_m_tkeep = '0;

        // Reset with every request and core handshake input asserted.
        resetn = 1'b0;
        clear_stim();
        s_cmd_tvalid = '1; s_ad_tvalid = '1; s_tvalid = '1; s_tag_tvalid = '1;
        m_ad_tready = '1; m_tready = '1; m_tag_tready = '1;
        c_s_cmd_tready = 1'b1; c_s_ad_tready = 1'b1; c_s_tready = 1'b1; c_s_tag_tready = 1'b1;
        c_m_ad_tvalid = 1'b1; c_m_tvalid = 1'b1; c_m_tag_tvalid = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, '0);
        check("rst_valids", {c_s_cmd_tvalid, c_s_ad_tvalid, c_s_tvalid, c_s_tag_tvalid,
                             m_ad_tvalid, m_tvalid, m_tag_tvalid}, '0);
        check("rst_readies", {s_cmd_tready, s_ad_tready, s_tready, s_tag_tready,
                              c_m_ad_tready, c_m_tready, c_m_tag_tready}, '0);
        clear_stim();
        resetn = 1'b1;

        // Single enc message from client 0.
        s_cmd_tvalid = 3'b001;
        c_s_cmd_tready = 1'b1;
        #1;
        check("idle_cmd_rdy", s_cmd_tready, '0);
        check("idle_cmd_vld", c_s_cmd_tvalid, 1'b0);
        tick();
        check("cmd_busy", busy, 1'b1);
        check("cmd_grant", grant_id, 0);
        check("cmd_vld", c_s_cmd_tvalid, 1'b1);
        check("cmd_data0", c_s_cmd_tdata, cmd_word[0]);
        check("cmd_encbit", c_s_cmd_tdata[256], 1'b1);
        check("cmd_rdy0", s_cmd_tready, 3'b001);
        tick();
        // Clients 1 and 2 queue up while client 0 owns the core.
        s_cmd_tvalid = 3'b110;
        #1;
        check("run_cmd_rdy", s_cmd_tready, '0);
        check("run_cmd_vld", c_s_cmd_tvalid, 1'b0);
        c_s_cmd_tready = 1'b0;

        c_s_ad_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_ad_tvalid = 3'b001;
            s_ad_tdata[127:0] = ad_v[i];
            s_ad_tlast[0] = (i == 1);
            #1;
            check("ad_vld", c_s_ad_tvalid, 1'b1);
            check("ad_data", c_s_ad_tdata, ad_v[i]);
            check("ad_last", c_s_ad_tlast, (i == 1));
            check("ad_rdy", s_ad_tready, 3'b001);
            tick();
        end
        s_ad_tvalid = '0; c_s_ad_tready = 1'b0;

        c_s_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 3'b001;
            s_tdata[127:0] = pt_v[i];
            s_tlast[0] = (i == 2);
            s_tkeep[15:0] = (i == 2) ? 16'h00FF : 16'hFFFF;
            #1;
            check("pt_data", c_s_tdata, pt_v[i]);
            check("pt_keep", c_s_tkeep, (i == 2) ? 16'h00FF : 16'hFFFF);
            check("pt_last", c_s_tlast, (i == 2));
            tick();
        end
        s_tvalid = '0; c_s_tready = 1'b0;

        c_m_tvalid = 1'b1;
        c_m_tdata = 128'hC1C1_0000_0000_0000_0000_0000_0000_0001;
        m_tready = 3'b001;
        #1;
        check("ct_vld", m_tvalid, 3'b001);
        check("ct_data", m_tdata[127:0], 128'hC1C1_0000_0000_0000_0000_0000_0000_0001);
        check("ct_rdy", c_m_tready, 1'b1);
        tick();
        // Owner stalls; other clients' readies must not leak through.
        c_m_tdata = 128'hC2C2_0000_0000_0000_0000_0000_0000_0002;
        m_tready = 3'b110;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_core_rdy", c_m_tready, 1'b0);
            check("bp_vld", m_tvalid, 3'b001);
            check("bp_data", m_tdata[127:0], 128'hC2C2_0000_0000_0000_0000_0000_0000_0002);
            check("bp_cmd_rdy", s_cmd_tready, '0);
            tick();
        end
        m_tready = 3'b001;
        #1;
        check("bp_release", c_m_tready, 1'b1);
        tick();
        c_m_tvalid = 1'b0; m_tready = '0;

        s_tag_tvalid = 3'b001;
        s_tag_tdata[127:0] = 128'h7A67_0000_0000_0000_0000_0000_0000_00AA;
        c_s_tag_tready = 1'b1;
        #1;
        check("tagin_vld", c_s_tag_tvalid, 1'b1);
        check("tagin_data", c_s_tag_tdata, 128'h7A67_0000_0000_0000_0000_0000_0000_00AA);
        check("tagin_rdy", s_tag_tready, 3'b001);
        tick();
        s_tag_tvalid = '0; c_s_tag_tready = 1'b0;

        c_m_tag_tvalid = 1'b1;
        c_m_tag_tdata = 128'hFEED_0000_0000_0000_0000_0000_0000_0077;
        m_tag_tready = 3'b001;
        #1;
        check("tag_vld", m_tag_tvalid, 3'b001);
        check("tag_data", m_tag_tdata[127:0], 128'hFEED_0000_0000_0000_0000_0000_0000_0077);
        check("tag_core_rdy", c_m_tag_tready, 1'b1);
        check("tag_busy", busy, 1'b1);
        tick();
        c_m_tag_tvalid = 1'b0; m_tag_tready = '0;
        check("post_tag_busy", busy, 1'b0);
        check("post_tag_grant", grant_id, 0);
        check("post_tag_cmd_vld", c_s_cmd_tvalid, 1'b0);

        // After client 0, queued clients 1 then 2; then wrap from 2 to 0.
        run_msg(1, 3'b100);
        run_msg(2, 3'b011);
        run_msg(0, 3'b011);
        run_msg(1, 3'b100);

        // Reset asynchronously while client 2 is in RUN.
        tick();
        tick();
        check("pre_rst_grant", grant_id, 2);
        c_s_cmd_tready = 1'b1;
        tick();
        c_s_cmd_tready = 1'b0;
        s_cmd_tvalid = '0;
        s_ad_tvalid = '1; c_s_ad_tready = 1'b1; c_m_tvalid = 1'b1; m_tready = '1;
        #1;
        check("pre_rst_ad_rdy", s_ad_tready, 3'b100);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_grant", grant_id, '0);
        check("arst_valids", {c_s_ad_tvalid, m_tvalid}, '0);
        check("arst_readies", {s_ad_tready, c_m_tready}, '0);
        clear_stim();
        s_cmd_tvalid = 3'b011;
        tick();
        resetn = 1'b1;

        // Both continuously requesting after reset: strict alternation starting with 0.
        run_msg(0, 3'b011);
        run_msg(1, 3'b011);
        run_msg(0, 3'b011);
        run_msg(1, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_ascon_aead128_arbiter.md
# axis_ascon_aead128_arbiter

Round-robin arbiter that shares one `axis_ascon_aead128` core between `num_clients` AXI-Stream requesters. Each client submits a complete message (cmd, AD, payload, tag-in) and receives the core's AD, payload and tag outputs. Ownership of the core is held per message, from grant until the core's output tag handshake. The block sits between the client-side stream fabric and a single core instance; it adds no data-path registers.

## Interface
Parameters:
- `num_clients`, 2, number of requesters; legal range 2..8.
- `cw`, `max(1,$clog2(num_clients))`, grant index width; derived, never overridden.

Ports. Per-client buses are packed vectors with client k at slice k; braces list the signals of one stream.
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `s_cmd_{tvalid,tready,tdata}`  in/out/in  N/N/N*512  client commands; bit 256 of each 512-bit word is enc/dec, passed unchanged.
- `s_ad_{tvalid,tready,tlast,tdata,tkeep}`  in/out/in/in/in  N/N/N/N*128/N*16  client AD in.
- `s_{tvalid,tready,tlast,tdata,tkeep}`  in/out/in/in/in  N/N/N/N*128/N*16  client payload in.
- `s_tag_{tvalid,tready,tdata}`  in/out/in  N/N/N*128  client tag in.
- `m_ad_{tvalid,tready,tlast,tdata,tkeep}`  out/in/out/out/out  N/N/N/N*128/N*16  AD returned to clients.
- `m_{tvalid,tready,tlast,tdata,tkeep}`  out/in/out/out/out  same widths  payload returned to clients.
- `m_tag_{tvalid,tready,tdata}`  out/in/out  N/N/N*128  tag returned to clients.
- `c_s_*`  out/in  single-client widths  same seven streams, core-facing; inputs to the core are driven by this block.
- `c_m_*`  in/out  single-client widths  core outputs; the block drives the readies.
- `busy`  out  1  high in CMD or RUN.
- `grant_id`  out  cw  current or last owner.

## Operation
- FSM states: IDLE, CMD, RUN.
- IDLE:
  - All client treadys are 0, all client `m_*_tvalid` are 0, all `c_s_*_tvalid` are 0, all `c_m_*_tready` are 0.
  - If any `s_cmd_tvalid` bit is set, latch `grant_id` = first requesting index strictly after `rr_ptr`, wrapping modulo `num_clients`, then go to CMD.
- CMD:
  - `c_s_cmd` is connected to client `grant_id`.
  - All other streams are gated as in IDLE.
  - On `c_s_cmd` handshake, go to RUN.
- RUN:
  - The three input streams (AD, payload, tag-in) of client `grant_id` are muxed to `c_s_*`.
  - The three core output streams are demuxed to client `grant_id`.
  - Every other client sees tready=0 and `m_*_tvalid`=0.
  - `s_cmd_tready` is 0 for all clients.
  - On `c_m_tag` handshake: `rr_ptr` ← `grant_id`, go to IDLE.
- Muxing: all muxes are purely combinational. tdata/tkeep/tlast on non-granted outputs are don't-care; tvalid is forced to 0.
- One message per grant. A client with back-to-back commands re-arbitrates after each tag.
- Reset:
  - State IDLE, `rr_ptr` = `num_clients-1` (client 0 wins first), `grant_id` = 0, `busy` = 0.
  - All tvalid and tready outputs are 0.
- Reset mid-message: the message is abandoned with no recovery. The core must share `resetn`.
- A client dropping `s_cmd_tvalid` after being latched is a protocol violation: the FSM waits in CMD indefinitely.

## Timing
- Data-path latency is zero; all stream paths are combinational pass-through while granted.
- Arbitration latency: request seen in IDLE at edge t → CMD from t+1 → earliest cmd handshake in cycle t+1.
- Turnaround: tag handshake at edge t → IDLE in cycle t+1 → next cmd handshake no earlier than cycle t+2. Simultaneous requests during this window are resolved in IDLE by round-robin.
- `busy` and `grant_id` are registered. `grant_id` is valid from the first CMD cycle and holds its value through IDLE.
- No combinational path from any `s_*_tvalid` to any client tready other than through the granted mux.

## Test plan
- Single client 0: enc message of 2 AD beats + 3 payload beats (last tkeep=16'h00FF) → core receives identical beats, client 0 gets ciphertext and tag; `busy` is high from CMD entry until the cycle after the tag handshake.
- Clients 0 and 1 request in the same cycle after reset → 0 is served first, 1 second; with both continuously requesting, grants alternate 0,1,0,1.
- `num_clients`=3, clients 1 and 2 request while client 0 owns the core → order after the tag is 1 then 2; client 0 stays gated throughout (tready=0, tvalid=0).
- Backpressure: `m_tready` of the granted client held low for 5 cycles → `c_m_tready` stays 0 and core output is held; other clients' `s_cmd_tready` stay 0.
- Enc then dec loopback through two clients sharing one core → dec tag output is 0, plaintext matches the original.
- `resetn` pulsed low in RUN → asynchronously all tvalid/tready 0, `busy` 0, `grant_id` 0; after release, client 0 wins the first arbitration.
